// File: rtl/conv_engine_param_if.sv
// Memory-side bus of conv_engine_param: X and Y read ports plus the Z write port.
// The engine takes the master modport; the memory subsystem takes the slave modport.
interface conv_engine_param_if #(
  parameter int DATA_W   = 8,
  parameter int ADDR_X_W = 5,
  parameter int ADDR_Y_W = 5,
  parameter int ADDR_Z_W = 6,
  parameter int ACC_W    = 24
);
  logic [ADDR_X_W-1:0] mem_x_addr_o;
  logic                mem_x_rd_o;
  logic [DATA_W-1:0]   mem_x_data_i;
  logic [ADDR_Y_W-1:0] mem_y_addr_o;
  logic                mem_y_rd_o;
  logic [DATA_W-1:0]   mem_y_data_i;
  logic [ADDR_Z_W-1:0] mem_z_addr_o;
  logic [ACC_W-1:0]    mem_z_data_o;
  logic                mem_z_wr_o;

  modport master (
    output mem_x_addr_o, mem_x_rd_o, input mem_x_data_i,
    output mem_y_addr_o, mem_y_rd_o, input mem_y_data_i,
    output mem_z_addr_o, mem_z_data_o, mem_z_wr_o
  );

  modport slave (
    input mem_x_addr_o, mem_x_rd_o, output mem_x_data_i,
    input mem_y_addr_o, mem_y_rd_o, output mem_y_data_i,
    input mem_z_addr_o, mem_z_data_o, mem_z_wr_o
  );
endinterface

// File: rtl/conv_engine_param.sv
// 1-D convolution engine Z[i] = sum_k X[k]*Y[i-k] with runtime sizes and a signed MAC.
// Optional feature macro CONV_ABORT_EN adds abort_i (abort to DONE with error, no write).
module conv_engine_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_X_W = 5,
  parameter int ADDR_Y_W = 5,
  parameter int ADDR_Z_W = 6,
  parameter int ACC_W    = 24,
  parameter int MEM_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [ADDR_X_W-1:0] size_x_i,
  input  logic [ADDR_Y_W-1:0] size_y_i,
`ifdef CONV_ABORT_EN
  input  logic                abort_i,
`endif
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  conv_engine_param_if.master mem
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ISSUE, S_DRAIN, S_WRITE, S_NEXT, S_DONE
  } state_t;

  localparam logic [ADDR_Z_W-1:0] ONE_Z = {{(ADDR_Z_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_X_W-1:0] r_sx;
  logic [ADDR_Y_W-1:0] r_sy;
  logic [ADDR_Z_W-1:0] r_i, r_k, r_k_hi;
  logic [1:0]          r_cnt;
  logic [MEM_LAT-1:0]  r_vld;
  logic [ACC_W-1:0]    r_acc;
  logic [ADDR_X_W-1:0] r_x_addr;
  logic [ADDR_Y_W-1:0] r_y_addr;
  logic [ADDR_Z_W-1:0] r_z_addr;
  logic [ACC_W-1:0]    r_z_data;
  logic                r_rd, r_z_wr, r_busy, r_done, r_err;

  logic                w_abort;
  logic                w_size_bad;
  logic [ADDR_Z_W-1:0] w_sx_z, w_sy_z, w_n_out, w_i_inc, w_i_p1, w_k_lo, w_k_hi;
  logic signed [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_acc_nxt;

`ifdef CONV_ABORT_EN
  assign w_abort = abort_i && (r_state != S_IDLE) && (r_state != S_DONE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_size_bad = (size_x_i == {ADDR_X_W{1'b0}}) || (size_y_i == {ADDR_Y_W{1'b0}});
  assign w_sx_z     = ADDR_Z_W'(r_sx);
  assign w_sy_z     = ADDR_Z_W'(r_sy);
  assign w_n_out    = w_sx_z + w_sy_z - ONE_Z;
  assign w_i_inc    = r_i + ONE_Z;
  assign w_i_p1     = w_i_inc + ONE_Z;
  // First and last valid X index for the upcoming output sample.
  assign w_k_lo     = (w_i_p1 > w_sy_z) ? (w_i_p1 - w_sy_z) : {ADDR_Z_W{1'b0}};
  assign w_k_hi     = (w_i_inc < (w_sx_z - ONE_Z)) ? w_i_inc : (w_sx_z - ONE_Z);
  assign w_prod     = $signed(mem.mem_x_data_i) * $signed(mem.mem_y_data_i);
  assign w_acc_nxt  = r_vld[MEM_LAT-1] ? (r_acc + ACC_W'(w_prod)) : r_acc;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = w_size_bad ? S_DONE : S_INIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_INIT:  w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = (r_k == r_k_hi) ? S_DRAIN : S_ISSUE;
      S_DRAIN: w_state_nxt = (r_cnt == 2'(MEM_LAT - 1)) ? S_WRITE : S_DRAIN;
      S_WRITE: w_state_nxt = S_NEXT;
      S_NEXT:  w_state_nxt = (w_i_inc == w_n_out) ? S_DONE : S_ISSUE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = S_DONE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // Datapath, MAC and registered outputs; outputs trail the state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sx <= '0; r_sy <= '0; r_i <= '0; r_k <= '0; r_k_hi <= '0;
      r_cnt <= 2'd0; r_vld <= '0; r_acc <= '0;
      r_x_addr <= '0; r_y_addr <= '0; r_z_addr <= '0; r_z_data <= '0;
      r_rd <= 1'b0; r_z_wr <= 1'b0; r_busy <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
    end else begin
      r_rd   <= 1'b0;
      r_z_wr <= 1'b0;
      r_busy <= (r_state != S_IDLE) && (r_state != S_DONE);
      r_done <= (r_state == S_DONE);
      r_acc  <= w_acc_nxt;
      // Valid pipeline follows the strobe the memory actually sees.
      r_vld[0] <= r_rd;
      for (int j = 1; j < MEM_LAT; j++) begin
        r_vld[j] <= r_vld[j-1];
      end
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_sx  <= size_x_i;
            r_sy  <= size_y_i;
            r_err <= w_size_bad;
          end
        end
        S_INIT: begin
          r_i <= '0; r_k <= '0; r_k_hi <= '0; r_acc <= '0;
        end
        S_ISSUE: begin
          r_rd     <= !w_abort;
          r_x_addr <= ADDR_X_W'(r_k);
          r_y_addr <= ADDR_Y_W'(r_i - r_k);
          r_k      <= r_k + ONE_Z;
          r_cnt    <= 2'd0;
        end
        S_DRAIN: r_cnt <= r_cnt + 2'd1;
        S_WRITE: begin
          r_z_wr   <= !w_abort;
          r_z_addr <= r_i;
          r_z_data <= w_acc_nxt;
        end
        S_NEXT: begin
          r_i <= w_i_inc; r_k <= w_k_lo; r_k_hi <= w_k_hi; r_acc <= '0;
        end
        default: ;
      endcase
      if (w_abort) begin
        r_err <= 1'b1;
        r_vld <= '0;
      end
    end
  end

  assign mem.mem_x_addr_o = r_x_addr;
  assign mem.mem_x_rd_o   = r_rd;
  assign mem.mem_y_addr_o = r_y_addr;
  assign mem.mem_y_rd_o   = r_rd;
  assign mem.mem_z_addr_o = r_z_addr;
  assign mem.mem_z_data_o = r_z_data;
  assign mem.mem_z_wr_o   = r_z_wr;
  assign busy_o = r_busy;
  assign done_o = r_done;
  assign err_o  = r_err;

endmodule

// File: tb/tb_conv_engine_param.sv
// Self-checking bench for conv_engine_param: two instances (MEM_LAT 1 and 3) against a
// direct-sum convolution model, latency formula and strobe counts.
module tb_conv_engine_param;
  localparam int DW = 8, AX = 5, AY = 5, AZ = 6, AW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    start_s;
  logic [AX-1:0] sx_s [2];
  logic [AY-1:0] sy_s [2];
`ifdef CONV_ABORT_EN
  logic [1:0]    abort_s;
`endif
  logic busy_w [2], done_w [2], err_w [2], outs_nz [2];

  logic signed [DW-1:0] xm [32];
  logic signed [DW-1:0] ym [32];
  logic [AW-1:0] exp_z [64];
  int sx_cur, sy_cur;
  int cyc = 0;
  int checks = 0, errors = 0;
  int rd_cnt [2], wr_cnt [2], done_cnt [2], wr_base [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", nm, got, expv, $time);
    end
  endtask

  function automatic int ml_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_d
    localparam int ML = (g == 0) ? 1 : 3;
    conv_engine_param_if #(.DATA_W(DW), .ADDR_X_W(AX), .ADDR_Y_W(AY), .ADDR_Z_W(AZ), .ACC_W(AW)) mif ();
    conv_engine_param #(.DATA_W(DW), .ADDR_X_W(AX), .ADDR_Y_W(AY), .ADDR_Z_W(AZ),
                        .ACC_W(AW), .MEM_LAT(ML)) u_dut (
      .clk(clk), .rst(rst), .start_i(start_s[g]), .size_x_i(sx_s[g]), .size_y_i(sy_s[g]),
`ifdef CONV_ABORT_EN
      .abort_i(abort_s[g]),
`endif
      .busy_o(busy_w[g]), .done_o(done_w[g]), .err_o(err_w[g]), .mem(mif)
    );

    logic [DW-1:0] xq [ML];
    logic [DW-1:0] yq [ML];
    logic xv [ML];
    logic yv [ML];
    logic [DW-1:0] gx, gy;

    // Memory with ML cycles of read latency; garbage is driven whenever data is not valid.
    always @(posedge clk) begin
      gx <= DW'($urandom);
      gy <= DW'($urandom);
      xq[0] <= xm[mif.mem_x_addr_o];
      yq[0] <= ym[mif.mem_y_addr_o];
      xv[0] <= mif.mem_x_rd_o;
      yv[0] <= mif.mem_y_rd_o;
      for (int j = 1; j < ML; j++) begin
        xq[j] <= xq[j-1]; yq[j] <= yq[j-1]; xv[j] <= xv[j-1]; yv[j] <= yv[j-1];
      end
    end
    assign mif.mem_x_data_i = xv[ML-1] ? xq[ML-1] : gx;
    assign mif.mem_y_data_i = yv[ML-1] ? yq[ML-1] : gy;
    assign outs_nz[g] = busy_w[g] | done_w[g] | err_w[g] | mif.mem_x_rd_o | mif.mem_y_rd_o |
                        mif.mem_z_wr_o | (|mif.mem_x_addr_o) | (|mif.mem_y_addr_o) |
                        (|mif.mem_z_addr_o) | (|mif.mem_z_data_o);

    // Compare process: every strobe is checked against the model as it happens.
    always @(negedge clk) begin
      if (mif.mem_x_rd_o) begin
        rd_cnt[g]++;
        chk("rd_pair", mif.mem_y_rd_o, 1);
        chk("x_addr_range", int'(mif.mem_x_addr_o) < sx_cur, 1);
        chk("y_addr_range", int'(mif.mem_y_addr_o) < sy_cur, 1);
        chk("xy_index_sum", int'(mif.mem_x_addr_o) + int'(mif.mem_y_addr_o), wr_cnt[g] - wr_base[g]);
      end
      if (mif.mem_z_wr_o) begin
        chk("z_addr", mif.mem_z_addr_o, wr_cnt[g] - wr_base[g]);
        chk("z_data", mif.mem_z_data_o, exp_z[mif.mem_z_addr_o]);
        wr_cnt[g]++;
      end
      if (done_w[g]) done_cnt[g]++;
    end
  end

  task automatic calc_model(input int sx, input int sy);
    int s, a, b;
    for (int i = 0; i < 64; i++) exp_z[i] = '0;
    for (int i = 0; i <= sx + sy - 2; i++) begin
      s = 0;
      for (int k = 0; k < sx; k++) begin
        if (i - k >= 0 && i - k < sy) begin
          a = xm[k];
          b = ym[i-k];
          s = s + a * b;
        end
      end
      exp_z[i] = AW'(s);
    end
  endtask

  task automatic wait_done(input int g);
    bit got = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      if (done_w[g]) begin got = 1'b1; break; end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic run_case(input int g, input int sx, input int sy, input bit hold, output int lat);
    int t0, rb, db, n_rd, n_wr;
    bit bad;
    bad  = (sx == 0) || (sy == 0);
    n_rd = bad ? 0 : sx * sy;
    n_wr = bad ? 0 : sx + sy - 1;
    if (!bad) calc_model(sx, sy);
    sx_cur = sx; sy_cur = sy;
    @(posedge clk); #1;
    start_s[g] = 1'b1; sx_s[g] = AX'(sx); sy_s[g] = AY'(sy);
    t0 = cyc; rb = rd_cnt[g]; db = done_cnt[g]; wr_base[g] = wr_cnt[g];
    if (!hold) begin
      @(posedge clk); #1;
      start_s[g] = 1'b0; sx_s[g] = AX'($urandom); sy_s[g] = AY'($urandom);
    end
    wait_done(g);
    lat = cyc - t0 - 1;
    chk("err_at_done", err_w[g], bad);
    chk("busy_at_done", busy_w[g], 0);
    if (!bad) chk("latency", lat, 2 + sx * sy + (sx + sy - 1) * (ml_of(g) + 2));
    @(posedge clk); #1;
    chk("done_single", done_w[g], 0);
    chk("done_cnt", done_cnt[g] - db, 1);
    chk("rd_cnt", rd_cnt[g] - rb, n_rd);
    chk("wr_cnt", wr_cnt[g] - wr_base[g], n_wr);
    if (hold) begin
      start_s[g] = 1'b0;
      rb = rd_cnt[g]; db = done_cnt[g]; wr_base[g] = wr_cnt[g];
      wait_done(g);
      @(posedge clk); #1;
      chk("hold_done_cnt", done_cnt[g] - db, 1);
      chk("hold_rd_cnt", rd_cnt[g] - rb, n_rd);
      chk("hold_wr_cnt", wr_cnt[g] - wr_base[g], n_wr);
    end
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 32; i++) begin
      xm[i] = DW'($urandom);
      ym[i] = DW'($urandom);
    end
  endtask

  initial begin
    int lat, rb, wb, g, sx, sy;
    bit hit;
    rst = 1'b1; start_s = 2'b00;
    sx_s[0] = '0; sx_s[1] = '0; sy_s[0] = '0; sy_s[1] = '0;
`ifdef CONV_ABORT_EN
    abort_s = 2'b00;
`endif
    for (int i = 0; i < 32; i++) begin xm[i] = '0; ym[i] = '0; end
    for (int i = 0; i < 2; i++) begin rd_cnt[i] = 0; wr_cnt[i] = 0; done_cnt[i] = 0; wr_base[i] = 0; end
    sx_cur = 0; sy_cur = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs_ml1", outs_nz[0], 0);
    chk("reset_outs_ml3", outs_nz[1], 0);
    rst = 1'b0;

    // Small worked example, MEM_LAT=1.
    xm[0] = 8'sd1; xm[1] = 8'sd2; xm[2] = 8'sd3; ym[0] = 8'sd1; ym[1] = 8'sd1;
    run_case(0, 3, 2, 1'b0, lat);
    chk("model_ex1_z0", exp_z[0], 24'd1);
    chk("model_ex1_z1", exp_z[1], 24'd3);
    chk("model_ex1_z2", exp_z[2], 24'd5);
    chk("model_ex1_z3", exp_z[3], 24'd3);
    chk("ex1_latency_20", lat, 20);
    chk("ex1_err", err_w[0], 0);

    // Extreme single-sample products on both latencies.
    xm[0] = -8'sd128; ym[0] = -8'sd128;
    run_case(0, 1, 1, 1'b0, lat);
    chk("model_min_sq", exp_z[0], 24'd16384);
    run_case(1, 1, 1, 1'b0, lat);
    xm[0] = 8'sd127; ym[0] = -8'sd1;
    run_case(1, 1, 1, 1'b0, lat);
    chk("model_neg", exp_z[0], 24'hFFFF81);

    // Zero size: error, no strobes; err sticks until the next valid start.
    run_case(0, 0, 4, 1'b0, lat);
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky", err_w[0], 1);
    run_case(0, 2, 2, 1'b0, lat);
    chk("err_cleared", err_w[0], 0);

    // MEM_LAT=3 worked example.
    xm[0] = 8'sd1; xm[1] = -8'sd1; xm[2] = 8'sd2; xm[3] = 8'sd0;
    ym[0] = 8'sd2; ym[1] = 8'sd1; ym[2] = -8'sd1;
    run_case(1, 4, 3, 1'b0, lat);
    chk("model_ex3_z0", exp_z[0], 24'd2);
    chk("model_ex3_z1", exp_z[1], 24'hFFFFFF);
    chk("model_ex3_z2", exp_z[2], 24'd2);
    chk("model_ex3_z3", exp_z[3], 24'd3);
    chk("model_ex3_z4", exp_z[4], 24'hFFFFFE);
    chk("model_ex3_z5", exp_z[5], 24'd0);

    // Reset in the middle of the read phase.
    rand_mem();
    calc_model(4, 4);
    sx_cur = 4; sy_cur = 4;
    @(posedge clk); #1;
    start_s[0] = 1'b1; sx_s[0] = AX'(4); sy_s[0] = AY'(4);
    rb = rd_cnt[0]; wr_base[0] = wr_cnt[0];
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (rd_cnt[0] - rb >= 3) begin hit = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("rst_reach_issue", hit, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_outs_ml1", outs_nz[0], 0);
    chk("rst_mid_outs_ml3", outs_nz[1], 0);
    rst = 1'b0;
    rb = rd_cnt[0]; wb = wr_cnt[0];
    repeat (20) @(posedge clk);
    #1;
    chk("rst_no_rd", rd_cnt[0] - rb, 0);
    chk("rst_no_wr", wr_cnt[0] - wb, 0);
    chk("rst_idle", busy_w[0], 0);
    run_case(0, 4, 4, 1'b0, lat);

    // start_i held through a whole run.
    rand_mem();
    run_case(0, 2, 3, 1'b1, lat);

    // Randomized sizes and data on both latencies.
    for (int r = 0; r < 8; r++) begin
      rand_mem();
      g  = r % 2;
      sx = $urandom_range(1, 9);
      sy = $urandom_range(1, 9);
      run_case(g, sx, sy, 1'b0, lat);
    end
    rand_mem();
    run_case(1, 31, 2, 1'b0, lat);

`ifdef CONV_ABORT_EN
    rand_mem();
    calc_model(5, 5);
    sx_cur = 5; sy_cur = 5;
    @(posedge clk); #1;
    start_s[1] = 1'b1; sx_s[1] = AX'(5); sy_s[1] = AY'(5);
    rb = rd_cnt[1]; wr_base[1] = wr_cnt[1];
    @(posedge clk); #1;
    start_s[1] = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (rd_cnt[1] - rb >= 3) break;
      @(posedge clk); #1;
    end
    abort_s[1] = 1'b1;
    rb = rd_cnt[1]; wb = wr_cnt[1];
    @(posedge clk); #1;
    abort_s[1] = 1'b0;
    wait_done(1);
    chk("abort_err", err_w[1], 1);
    chk("abort_no_wr", wr_cnt[1] - wb, 0);
    chk("abort_rd_stop", (rd_cnt[1] - rb) <= 1, 1);
    @(posedge clk); #1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_engine_param.md
Name: conv_engine_param

Overview:
- Parametrised 1-D discrete convolution engine: Z[i] = sum over k of X[k]*Y[i-k], for i = 0 .. size_x+size_y-2.
- Successor to the fixed-function convolution FSM controller. Adds the following in one block:
  - runtime sequence lengths;
  - internal index and address generation;
  - configurable memory read latency;
  - a signed MAC accumulator;
  - error reporting.
- Sits between the register/host interface (start, sizes, status) and three single-port memories (X, Y read; Z write).

Parameters:
- DATA_W, 8: width of X/Y samples, signed two's complement.
- ADDR_X_W, 5: X address width; size_x range 1..2^ADDR_X_W-1.
- ADDR_Y_W, 5: Y address width; size_y range 1..2^ADDR_Y_W-1.
- ADDR_Z_W, 6: Z address width; must be at least max(ADDR_X_W,ADDR_Y_W)+1.
- ACC_W, 24: accumulator and Z sample width, signed.
- MEM_LAT, 1: X/Y read latency in cycles, 1..3.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  start request, sampled only in IDLE
- size_x_i  in  ADDR_X_W  X length, latched at start
- size_y_i  in  ADDR_Y_W  Y length, latched at start
- mem_x_addr_o  out  ADDR_X_W  X read address
- mem_x_rd_o  out  1  X read strobe
- mem_x_data_i  in  DATA_W  X read data, valid MEM_LAT cycles after strobe
- mem_y_addr_o  out  ADDR_Y_W  Y read address
- mem_y_rd_o  out  1  Y read strobe
- mem_y_data_i  in  DATA_W  Y read data, valid MEM_LAT cycles after strobe
- mem_z_addr_o  out  ADDR_Z_W  Z write address
- mem_z_data_o  out  ACC_W  Z write data
- mem_z_wr_o  out  1  Z write strobe, one cycle per sample
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error flag, cleared on next accepted start

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high, port rst.
  - All outputs are registered; there is no combinational input-to-output path.
- Reset: every output is 0. State = IDLE, accumulator = 0, valid pipeline = 0.
  - Reset asserted mid-operation aborts immediately; no further memory strobes or Z writes occur.
- IDLE:
  - busy_o = 0.
  - start_i = 1 latches sx = size_x_i and sy = size_y_i, then clears err_o.
  - If sx = 0 or sy = 0: set err_o = 1 and go to DONE. No memory accesses occur.
  - Otherwise go to INIT.
- INIT:
  - busy_o = 1. Set i = 0, k = 0, k_hi = min(i, sx-1), accumulator = 0.
  - Next state: ISSUE.
- ISSUE:
  - Each cycle asserts mem_x_rd_o and mem_y_rd_o together, with mem_x_addr_o = k and mem_y_addr_o = i-k. Then k increments.
  - The last issue occurs at k = k_hi; next state is DRAIN.
  - Terms issued per output sample: n_i = k_hi - k_lo + 1.
- Valid pipeline:
  - A MEM_LAT-deep shift register delays the read strobe.
  - When the delayed strobe is 1: acc <= acc + sext(x*y).
  - The product is a signed 2*DATA_W value, sign-extended to ACC_W. The sum wraps modulo 2^ACC_W with no saturation.
- DRAIN: waits exactly MEM_LAT cycles so the last product is accumulated, then goes to WRITE.
- WRITE: mem_z_wr_o = 1 for one cycle, mem_z_addr_o = i, mem_z_data_o = acc.
- NEXT:
  - i increments.
  - If i = sx+sy-1, go to DONE.
  - Otherwise:
    - set k = k_lo = max(0, i-sy+1);
    - set k_hi = min(i, sx-1);
    - set acc = 0;
    - go to ISSUE.
- DONE: done_o = 1 and busy_o = 0 for one cycle, then IDLE.
- Latency: cycles from the start-accept edge to done_o high = 2 + sx*sy + (sx+sy-1)*(MEM_LAT+2).
- start_i while busy_o = 1 is ignored. Size inputs are don't-care outside the start-accept cycle.
- Strobe outputs (rd/wr) are 0 in every state other than those listed above. Address and data outputs hold their last value.

Optional Feature:
- Macro: CONV_ABORT_EN.
- Defined:
  - Adds input abort_i (1 bit).
  - abort_i = 1 in any state other than IDLE/DONE forces the next state to DONE, with done_o = 1 and err_o = 1.
  - Read strobes stop the following cycle. Any pending accumulation is discarded and no WRITE occurs for the current sample.
- Undefined: no abort_i port; the operation always runs to completion.

Test Plan:
- sx=3, sy=2, X=[1,2,3], Y=[1,1], MEM_LAT=1 -> writes Z[0..3]=[1,3,5,3] at addresses 0..3; done_o exactly 20 cycles after start accept; err_o=0.
- sx=1, sy=1, X=[-128], Y=[-128] -> single write Z[0]=16384; sx=1, sy=1, X=[127], Y=[-1] -> Z[0]=-127.
- size_x_i=0, sy=4, start -> no rd/wr strobes; done_o pulses; err_o=1, stays 1 until the next valid start, which clears it.
- MEM_LAT=3, sx=4, sy=3, X=[1,-1,2,0], Y=[2,1,-1] -> Z=[2,-1,2,3,-2,0]; rd strobes=12, wr strobes=6.
- rst=1 during the third ISSUE cycle of a run -> next cycle all outputs are 0 and state is IDLE; no mem_z_wr_o follows; a new start completes correctly.
- start_i held high through an entire run -> exactly one run; a second run begins only after returning to IDLE (with CONV_ABORT_EN: abort_i mid-ISSUE -> done_o and err_o=1, no write).
